axi4_stream_video_out: RTL

Display-side output stage that sits directly downstream of `frame_buffer`. It consumes the frame buffer's read-side AXI4-Stream video (`tuser` = start of frame, `tlast` = end of line) and regenerates a free-running raster. The raster carries `de`/`hsync`/`vsync` and pixel data for a video encoder or PHY. The block locks the stream to the raster on start of frame, applies backpressure outside the active area, and detects underflow and framing errors, re-locking on the next start of frame.

---
 rtl/axi4_stream_video_out_if.sv | 15 +
 rtl/axi4_stream_video_out.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/axi4_stream_video_out_if.sv
// AXI4-Stream video link between the frame buffer read side and the
// display output stage. tuser[0] marks start of frame, tlast marks end of line.
interface axi4_stream_if #(
  parameter int TDATA_WIDTH = 16,
  parameter int TUSER_WIDTH = 1
);
  logic                   tvalid;
  logic                   tready;
  logic [TDATA_WIDTH-1:0] tdata;
  logic [TUSER_WIDTH-1:0] tuser;
  logic                   tlast;

  modport master (output tvalid, output tdata, output tuser, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tuser, input tlast, output tready);
endinterface

// File: rtl/axi4_stream_video_out.sv
// Display output stage: free-running raster generator that locks the
// incoming AXI4-Stream video onto the raster at start of frame, blanks and
// unlocks on underflow or framing errors, and re-locks at the next frame.
module axi4_stream_video_out #(
  parameter int PX_WIDTH     = 10,
  parameter int TDATA_WIDTH  = 16,
  parameter int FRAME_RES_X  = 1920,
  parameter int FRAME_RES_Y  = 1080,
  parameter int TOTAL_X      = 2200,
  parameter int TOTAL_Y      = 1125,
  parameter int H_SYNC_START = 2008,
  parameter int H_SYNC_LEN   = 44,
  parameter int V_SYNC_START = 1084,
  parameter int V_SYNC_LEN   = 5
) (
  input  logic                clk_i,
  input  logic                rst_i,
  axi4_stream_if.slave        video_i,
  output logic [PX_WIDTH-1:0] px_data_o,
  output logic                de_o,
  output logic                hs_o,
  output logic                vs_o,
  output logic                locked_o,
  output logic                underflow_o,
  output logic                err_o
);

  localparam int HW = (TOTAL_X > 1) ? $clog2(TOTAL_X) : 1;
  localparam int VW = (TOTAL_Y > 1) ? $clog2(TOTAL_Y) : 1;

  // Raster limits kept 32 bits wide so that sync window ends equal to a
  // power-of-two total still compare correctly against the counters.
  localparam logic [31:0] LP_RES_X    = 32'(FRAME_RES_X);
  localparam logic [31:0] LP_RES_Y    = 32'(FRAME_RES_Y);
  localparam logic [31:0] LP_LAST_X   = 32'(TOTAL_X - 1);
  localparam logic [31:0] LP_LAST_Y   = 32'(TOTAL_Y - 1);
  localparam logic [31:0] LP_HS_START = 32'(H_SYNC_START);
  localparam logic [31:0] LP_HS_END   = 32'(H_SYNC_START + H_SYNC_LEN);
  localparam logic [31:0] LP_VS_START = 32'(V_SYNC_START);
  localparam logic [31:0] LP_VS_END   = 32'(V_SYNC_START + V_SYNC_LEN);

  typedef enum logic {
    SEEK_SOF = 1'b0,
    STREAM   = 1'b1
  } state_t;

  state_t              r_state;
  logic [HW-1:0]       r_h_cnt;
  logic [VW-1:0]       r_v_cnt;
  logic [PX_WIDTH-1:0] r_px_data;
  logic                r_de;
  logic                r_hs;
  logic                r_vs;
  logic                r_locked;
  logic                r_underflow;
  logic                r_err;

  logic [31:0]         w_h_ext;
  logic [31:0]         w_v_ext;
  logic                w_h_wrap;
  logic                w_v_wrap;
  logic                w_active;
  logic                w_origin;
  logic                w_line_end;
  logic                w_hs;
  logic                w_vs;
  logic                w_sof;
  logic                w_tready;
  logic                w_frame_err;
  logic                w_unused;

  assign w_h_ext    = 32'(r_h_cnt);
  assign w_v_ext    = 32'(r_v_cnt);
  assign w_h_wrap   = (w_h_ext == LP_LAST_X);
  assign w_v_wrap   = (w_v_ext == LP_LAST_Y);
  assign w_active   = (w_h_ext < LP_RES_X) && (w_v_ext < LP_RES_Y);
  assign w_origin   = (r_h_cnt == '0) && (r_v_cnt == '0);
  assign w_line_end = (w_h_ext == LP_RES_X - 32'd1);
  assign w_hs       = (w_h_ext >= LP_HS_START) && (w_h_ext < LP_HS_END);
  assign w_vs       = (w_v_ext >= LP_VS_START) && (w_v_ext < LP_VS_END);

  // Only the low PX_WIDTH bits of tdata carry pixel data.
  assign w_unused = ^video_i.tdata[TDATA_WIDTH-1:0];

  // A start-of-frame beat may only be taken exactly at raster origin.
  assign w_sof = w_origin & video_i.tvalid & video_i.tuser[0];

  // A beat is misframed if it claims SOF away from the origin or its
  // end-of-line marker disagrees with the raster column.
  assign w_frame_err = (video_i.tuser[0] & ~w_origin) | (video_i.tlast != w_line_end);

  // Ready: while seeking, drain non-SOF beats and hold a SOF until origin;
  // while streaming, pull exactly one beat per active pixel. Reset forces 0.
  always_comb begin
    w_tready = 1'b0;
    if (!rst_i) begin
      case (r_state)
        SEEK_SOF: w_tready = video_i.tvalid & (~video_i.tuser[0] | w_origin);
        STREAM:   w_tready = w_active;
        default:  w_tready = 1'b0;
      endcase
    end
  end

  assign video_i.tready = w_tready;

  // Free-running raster counters, independent of the stream.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_wrap) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  // Timing outputs registered from the current raster position.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_de <= 1'b0;
      r_hs <= 1'b0;
      r_vs <= 1'b0;
    end else begin
      r_de <= w_active;
      r_hs <= w_hs;
      r_vs <= w_vs;
    end
  end

  // Lock FSM with registered pixel, lock flag and error pulses; locked
  // reflects the state being entered so it lines up with the pixel.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= SEEK_SOF;
      r_px_data   <= '0;
      r_locked    <= 1'b0;
      r_underflow <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_px_data   <= '0;
      r_underflow <= 1'b0;
      r_err       <= 1'b0;
      case (r_state)
        SEEK_SOF: begin
          if (w_sof) begin
            r_px_data <= video_i.tdata[PX_WIDTH-1:0];
            r_state   <= STREAM;
            r_locked  <= 1'b1;
          end else begin
            r_locked  <= 1'b0;
          end
        end
        STREAM: begin
          r_locked <= 1'b1;
          if (w_active) begin
            if (!video_i.tvalid) begin
              // Underflow wins: nothing was accepted, so no framing check.
              r_underflow <= 1'b1;
              r_state     <= SEEK_SOF;
              r_locked    <= 1'b0;
            end else begin
              r_px_data <= video_i.tdata[PX_WIDTH-1:0];
              if (w_frame_err) begin
                r_err    <= 1'b1;
                r_state  <= SEEK_SOF;
                r_locked <= 1'b0;
              end
            end
          end
        end
        default: begin
          r_state  <= SEEK_SOF;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  assign px_data_o   = r_px_data;
  assign de_o        = r_de;
  assign hs_o        = r_hs;
  assign vs_o        = r_vs;
  assign locked_o    = r_locked;
  assign underflow_o = r_underflow;
  assign err_o       = r_err;

endmodule
